encode_multi: RTL
=================

# encode_multi

Pipelined, parametrised 8b/10b encoder for the link transmit path. Accepts LANES bytes per cycle, each with a K flag, through a valid/ready handshake. Running disparity is chained lane-to-lane within a word and held in a register across words. Produces LANES 10-bit symbols per word after one register stage. Sits between the transmit framer and the serialiser.

## Interface
Parameters:
- LANES, 2: bytes encoded per word (1..8); lane 0 is transmitted first.

Ports:
- clk  in  1  single clock; all logic in this domain.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  encoder accepts the word this cycle.
- in_data  in  8*LANES  bytes; lane n at [8n+7:8n], bit order HGFEDCBA.
- in_k  in  LANES  control-symbol flag per lane.
- rd_load  in  1  overwrite running disparity this cycle.
- rd_load_val  in  1  value for rd_load; 0 = negative, 1 = positive.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  10*LANES  symbols; lane n at [10n+9:10n], bits {j,h,g,f,i,e,d,c,b,a}, a at LSB.
- out_illegal_k  out  LANES  per-lane flag: K flag set on a code that is not K28.0–.7, K23.7, K27.7, K29.7 or K30.7.
- rd  out  1  current running disparity register.

## Operation
- Per lane: standard Widmer–Franaszek 5b/6b and 3b/4b encoding, including alternate Dx.A7 selection for D11/13/14 (RD+) and D17/18/20 (RD−), and K28.x forms.
- Disparity chain: lane 0 uses rd (or rd_load_val when rd_load is high); lane n uses lane n−1 output disparity; last lane's output disparity is the next rd.
- rd updates only on input transfer (in_valid & in_ready). rd_load without transfer sets rd = rd_load_val. rd_load with transfer: rd_load_val is the chain input and rd takes the chain output.
- Illegal K: symbol is still encoded by the same logic; out_illegal_k bit set; disparity advances from the encoded symbol. No other error action.
- Output stage is a single pipeline register: in_ready = !out_valid | out_ready.

## Timing
- Reset values: out_valid 0, out_data 0, out_illegal_k 0, rd 0 (negative). in_ready is 1 after reset.
- Latency 1 cycle: word accepted at edge t appears on out_data from t+1.
- Full throughput: one word per cycle while out_ready is held high.
- Backpressure: out_valid high and out_ready low hold out_data, out_illegal_k and rd stable; in_ready is 0.
- Reset mid-operation drops any held word; no partial symbol is emitted.

## Configuration
- ENCODE_MULTI_IDLE_FILL_EN defined: when out_ready is high (or out_valid is 0) and in_valid is 0, the encoder loads an idle word: lane 0 K28.5, other lanes D5.6. This keeps out_valid continuously 1 after the first cycle out of reset; rd advances on idle words exactly as on data. in_ready is unaffected.
- Not defined: with no input, out_valid drops to 0 once the held word is taken; no symbols are generated.

## Structure
- Shared package encode_multi_pkg: K28_5 and D5_6 byte constants, the legal-K list, and a symbol type (10-bit) and lane-input type (K flag + 8-bit byte).
- One sub-module, enc_8b10b_lane: combinational byte + K + disparity-in to symbol + disparity-out + illegal-K. It is instantiated LANES times in a chain. The top module holds the rd register, handshake, output register and idle fill.

## Test plan
- LANES=1, after reset, D0.0 (0x00, k=0) -> out_data 0x0B9, rd stays 0.
- LANES=2, one word of K28.5,K28.5 from RD− -> out_data lane0 0x17C, lane1 0x283, rd 0.
- out_ready held low 5 cycles with in_valid high -> in_ready 0, out_data and rd stable, and no word is lost once out_ready rises.
- rd_load=1, rd_load_val=1 with a K28.5 transfer (LANES=1) -> 0x283, rd becomes 0. rd_load alone with no transfer -> rd = rd_load_val next cycle.
- k=1 with byte 0x00 -> out_illegal_k=1, symbol equals the K-flagged encoding, and rd advances by that symbol's disparity.
- With ENCODE_MULTI_IDLE_FILL_EN, in_valid=0 for 4 cycles (LANES=2) -> out_valid stays 1 and lane 0 alternates 0x17C/0x283 according to rd.

Source files
------------

// File: rtl/encode_multi_pkg.sv
// rtl/encode_multi_pkg.sv - shared constants, types and bit helpers for the 8b/10b encoder
package encode_multi_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D5_6  = 8'hC5;

    // Kx.7 codes other than K28.7 that are valid control symbols
    localparam logic [7:0] LEGAL_K7 [4] = '{8'hF7, 8'hFB, 8'hFD, 8'hFE};

    typedef logic [9:0] symbol_t;

    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } lane_in_t;

    function automatic logic is_legal_k(input logic [7:0] b);
        logic legal;
        legal = (b[4:0] == 5'd28);
        for (int i = 0; i < 4; i++) begin
            if (b == LEGAL_K7[i]) legal = 1'b1;
        end
        return legal;
    endfunction

    function automatic logic [2:0] count_ones6(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) n = n + 3'(v[i]);
        return n;
    endfunction

    function automatic logic [5:0] rev6(input logic [5:0] v);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = v[5-i];
        return r;
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = v[3-i];
        return r;
    endfunction

endpackage

// File: rtl/enc_8b10b_lane.sv
// rtl/enc_8b10b_lane.sv - combinational single-byte 8b/10b encoder with disparity in/out
module enc_8b10b_lane
    import encode_multi_pkg::*;
(
    input  lane_in_t lane_i,
    input  logic     rd_i,
    output symbol_t  sym_o,
    output logic     rd_o,
    output logic     illegal_k_o
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] code6n;
    logic [5:0] code6;
    logic [3:0] code4n;
    logic [3:0] code4;
    logic       bal6;
    logic       bal4;
    logic       rd_mid;
    logic       alt7;

    assign x = lane_i.data[4:0];
    assign y = lane_i.data[7:5];
    assign illegal_k_o = lane_i.k & ~is_legal_k(lane_i.data);

    // Tables hold the RD- column in abcdei / fghj order; RD+ is the complement where it differs
    always_comb begin
        code6n = 6'b000000;
        case (x)
            5'd0:  code6n = 6'b100111;
            5'd1:  code6n = 6'b011101;
            5'd2:  code6n = 6'b101101;
            5'd3:  code6n = 6'b110001;
            5'd4:  code6n = 6'b110101;
            5'd5:  code6n = 6'b101001;
            5'd6:  code6n = 6'b011001;
            5'd7:  code6n = 6'b111000;
            5'd8:  code6n = 6'b111001;
            5'd9:  code6n = 6'b100101;
            5'd10: code6n = 6'b010101;
            5'd11: code6n = 6'b110100;
            5'd12: code6n = 6'b001101;
            5'd13: code6n = 6'b101100;
            5'd14: code6n = 6'b011100;
            5'd15: code6n = 6'b010111;
            5'd16: code6n = 6'b011011;
            5'd17: code6n = 6'b100011;
            5'd18: code6n = 6'b010011;
            5'd19: code6n = 6'b110010;
            5'd20: code6n = 6'b001011;
            5'd21: code6n = 6'b101010;
            5'd22: code6n = 6'b011010;
            5'd23: code6n = 6'b111010;
            5'd24: code6n = 6'b110011;
            5'd25: code6n = 6'b100110;
            5'd26: code6n = 6'b010110;
            5'd27: code6n = 6'b110110;
            5'd28: code6n = 6'b001110;
            5'd29: code6n = 6'b101110;
            5'd30: code6n = 6'b011110;
            default: code6n = 6'b101011;
        endcase
        if (lane_i.k && x == 5'd28) code6n = 6'b001111;

        bal6   = (count_ones6(code6n) == 3'd3);
        code6  = (rd_i && (!bal6 || x == 5'd7)) ? ~code6n : code6n;
        rd_mid = bal6 ? rd_i : ~rd_i;

        alt7 = (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
               ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));

        code4n = 4'b0000;
        if (lane_i.k) begin
            // control 4b codes: stored as the RD+ column, inverted for RD-
            case (y)
                3'd0: code4n = 4'b0100;
                3'd1: code4n = 4'b1001;
                3'd2: code4n = 4'b0101;
                3'd3: code4n = 4'b0011;
                3'd4: code4n = 4'b0010;
                3'd5: code4n = 4'b1010;
                3'd6: code4n = 4'b0110;
                default: code4n = 4'b1000;
            endcase
            code4 = rd_mid ? code4n : ~code4n;
        end else begin
            case (y)
                3'd0: code4n = 4'b1011;
                3'd1: code4n = 4'b1001;
                3'd2: code4n = 4'b0101;
                3'd3: code4n = 4'b1100;
                3'd4: code4n = 4'b1101;
                3'd5: code4n = 4'b1010;
                3'd6: code4n = 4'b0110;
                default: code4n = alt7 ? 4'b0111 : 4'b1110;
            endcase
            code4 = (rd_mid && (count_ones6({2'b00, code4n}) != 3'd2 || y == 3'd3 || y == 3'd7))
                    ? ~code4n : code4n;
        end

        bal4  = (count_ones6({2'b00, code4}) == 3'd2);
        rd_o  = bal4 ? rd_mid : ~rd_mid;
        sym_o = {rev4(code4), rev6(code6)};
    end

endmodule

// File: rtl/encode_multi.sv
// rtl/encode_multi.sv - LANES-wide 8b/10b encoder with output register; ENCODE_MULTI_IDLE_FILL_EN adds idle fill
module encode_multi
    import encode_multi_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*LANES-1:0]    in_data,
    input  logic [LANES-1:0]      in_k,
    input  logic                  rd_load,
    input  logic                  rd_load_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10*LANES-1:0]   out_data,
    output logic [LANES-1:0]      out_illegal_k,
    output logic                  rd
);

    logic                     out_valid_q, out_valid_d;
    logic [10*LANES-1:0]      out_data_q, out_data_d;
    logic [LANES-1:0]         out_ill_q, out_ill_d;
    logic                     rd_q, rd_d;

    logic                     load_idle;
    logic                     load;
    logic [LANES:0]           chain_rd;
    lane_in_t                 lane_in [LANES];
    symbol_t [LANES-1:0]      lane_sym;
    logic [LANES-1:0]         lane_ill;

    assign in_ready = ~out_valid_q | out_ready;

`ifdef ENCODE_MULTI_IDLE_FILL_EN
    assign load_idle = in_ready & ~in_valid;
`else
    assign load_idle = 1'b0;
`endif

    assign load        = (in_valid & in_ready) | load_idle;
    assign chain_rd[0] = rd_load ? rd_load_val : rd_q;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        lane_in_t idle_lane;
        assign idle_lane = (n == 0) ? lane_in_t'{k: 1'b1, data: K28_5}
                                    : lane_in_t'{k: 1'b0, data: D5_6};
        assign lane_in[n] = load_idle ? idle_lane
                                      : lane_in_t'{k: in_k[n], data: in_data[8*n +: 8]};

        enc_8b10b_lane u_lane (
            .lane_i      (lane_in[n]),
            .rd_i        (chain_rd[n]),
            .sym_o       (lane_sym[n]),
            .rd_o        (chain_rd[n+1]),
            .illegal_k_o (lane_ill[n])
        );
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ill_d   = out_ill_q;
        rd_d        = rd_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_sym;
            out_ill_d   = lane_ill;
            rd_d        = chain_rd[LANES];
        end else begin
            if (in_ready) out_valid_d = 1'b0;
            if (rd_load)  rd_d        = rd_load_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ill_q   <= '0;
            rd_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ill_q   <= out_ill_d;
            rd_q        <= rd_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_illegal_k = out_ill_q;
    assign rd            = rd_q;

endmodule
